// File: rtl/inst_encoder.sv
// inst_encoder: packs format/register/immediate fields into RV32I machine words
// through a two-stage valid/ready pipeline, tagging each word with a program address.
// Optional macro INST_ENCODER_RANGE_CHECK_EN flags immediates that do not fit their format.

module inst_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       fmt,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic [31:0]      imm,
    input  logic             addr_load,
    input  logic [31:0]      addr_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [31:0]      out_addr,
    output logic             out_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] word_cnt
);

    localparam logic [31:0] L_BASE  = {BASE_ADDR[31:2], 2'b00};
    localparam logic [31:0] L_NOP   = 32'h0000_0013;
    localparam logic [3:0]  FMT_R   = 4'd1;
    localparam logic [3:0]  FMT_I   = 4'd2;
    localparam logic [3:0]  FMT_U   = 4'd3;
    localparam logic [3:0]  FMT_S   = 4'd4;
    localparam logic [3:0]  FMT_B   = 4'd5;
    localparam logic [3:0]  FMT_J   = 4'd6;
    localparam logic [3:0]  FMT_CSR = 4'd7;

    // Stage A: captured field bundle
    logic        r_a_valid;
    logic [3:0]  r_a_fmt;
    logic [6:0]  r_a_opcode;
    logic [4:0]  r_a_rd;
    logic [4:0]  r_a_rs1;
    logic [4:0]  r_a_rs2;
    logic [2:0]  r_a_func3;
    logic [6:0]  r_a_func7;
    logic [31:0] r_a_imm;

    // Stage B: packed word
    logic        r_b_valid;
    logic [31:0] r_inst;
    logic        r_err;

    logic [31:0]      r_addr;
    logic [CNT_W-1:0] r_word_cnt;
    logic             r_err_sticky;

    logic        w_b_adv;
    logic        w_a_adv;
    logic        w_in_fire;
    logic        w_out_fire;
    logic        w_is_shift;
    logic [31:0] w_pack_inst;
    logic        w_illegal;
    logic        w_range_err;
    logic        w_a_err;
    logic        w_unused_addr_lo;

    assign w_b_adv    = !r_b_valid || out_ready;
    assign w_a_adv    = !r_a_valid || w_b_adv;
    assign in_ready   = w_a_adv && !flush;
    assign w_in_fire  = in_valid && in_ready;
    // A flush cancels an output handshake in the same cycle.
    assign w_out_fire = r_b_valid && out_ready && !flush;

    assign w_is_shift = (r_a_opcode == 7'b0010011) &&
                        ((r_a_func3 == 3'b001) || (r_a_func3 == 3'b101));

    // The low address bits are always forced to zero on load.
    assign w_unused_addr_lo = ^addr_value[1:0];

    always_comb begin
        w_pack_inst = L_NOP;
        w_illegal   = 1'b0;
        case (r_a_fmt)
            FMT_R:   w_pack_inst = {r_a_func7, r_a_rs2, r_a_rs1, r_a_func3, r_a_rd, r_a_opcode};
            FMT_I: begin
                if (w_is_shift)
                    w_pack_inst = {r_a_func7, r_a_imm[4:0], r_a_rs1, r_a_func3, r_a_rd, r_a_opcode};
                else
                    w_pack_inst = {r_a_imm[11:0], r_a_rs1, r_a_func3, r_a_rd, r_a_opcode};
            end
            FMT_U:   w_pack_inst = {r_a_imm[31:12], r_a_rd, r_a_opcode};
            FMT_S:   w_pack_inst = {r_a_imm[11:5], r_a_rs2, r_a_rs1, r_a_func3,
                                    r_a_imm[4:0], r_a_opcode};
            FMT_B:   w_pack_inst = {r_a_imm[12], r_a_imm[10:5], r_a_rs2, r_a_rs1, r_a_func3,
                                    r_a_imm[4:1], r_a_imm[11], r_a_opcode};
            FMT_J:   w_pack_inst = {r_a_imm[20], r_a_imm[10:1], r_a_imm[11], r_a_imm[19:12],
                                    r_a_rd, r_a_opcode};
            FMT_CSR: w_pack_inst = {r_a_imm[11:0], r_a_rs1, r_a_func3, r_a_rd, r_a_opcode};
            default: begin
                w_pack_inst = L_NOP;
                w_illegal   = 1'b1;
            end
        endcase
    end

`ifdef INST_ENCODER_RANGE_CHECK_EN
    // Out-of-range immediates are still packed (truncated) but flagged.
    always_comb begin
        w_range_err = 1'b0;
        case (r_a_fmt)
            FMT_I: begin
                if (w_is_shift)
                    w_range_err = (r_a_imm[31:5] != '0);
                else
                    w_range_err = (r_a_imm[31:11] != {21{r_a_imm[11]}});
            end
            FMT_S:   w_range_err = (r_a_imm[31:11] != {21{r_a_imm[11]}});
            FMT_CSR: w_range_err = (r_a_imm[31:12] != '0);
            FMT_B:   w_range_err = (r_a_imm[31:12] != {20{r_a_imm[12]}}) || r_a_imm[0];
            FMT_J:   w_range_err = (r_a_imm[31:20] != {12{r_a_imm[20]}}) || r_a_imm[0];
            FMT_U:   w_range_err = (r_a_imm[11:0] != '0);
            default: w_range_err = 1'b0;
        endcase
    end
`else
    assign w_range_err = 1'b0;
`endif

    assign w_a_err = w_illegal || w_range_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_valid <= 1'b0;
        end else if (flush) begin
            r_a_valid <= 1'b0;
        end else if (w_a_adv) begin
            r_a_valid <= in_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_fmt    <= '0;
            r_a_opcode <= '0;
            r_a_rd     <= '0;
            r_a_rs1    <= '0;
            r_a_rs2    <= '0;
            r_a_func3  <= '0;
            r_a_func7  <= '0;
            r_a_imm    <= '0;
        end else if (w_in_fire) begin
            r_a_fmt    <= fmt;
            r_a_opcode <= opcode;
            r_a_rd     <= rd;
            r_a_rs1    <= rs1;
            r_a_rs2    <= rs2;
            r_a_func3  <= func3;
            r_a_func7  <= func7;
            r_a_imm    <= imm;
        end
    end

    // Word registers only load real data so out_inst never shows a stale bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b_valid <= 1'b0;
            r_inst    <= '0;
            r_err     <= 1'b0;
        end else if (flush) begin
            r_b_valid <= 1'b0;
        end else if (w_b_adv) begin
            r_b_valid <= r_a_valid;
            if (r_a_valid) begin
                r_inst <= w_pack_inst;
                r_err  <= w_a_err;
            end
        end
    end

    // A load wins over the increment; the departing word already saw the old address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= L_BASE;
        end else if (addr_load) begin
            r_addr <= {addr_value[31:2], 2'b00};
        end else if (w_out_fire) begin
            r_addr <= r_addr + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_cnt   <= '0;
            r_err_sticky <= 1'b0;
        end else if (w_out_fire) begin
            r_word_cnt   <= r_word_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            r_err_sticky <= r_err_sticky | r_err;
        end
    end

    assign out_valid  = r_b_valid;
    assign out_inst   = r_inst;
    assign out_err    = r_err;
    assign out_addr   = r_addr;
    assign word_cnt   = r_word_cnt;
    assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed vectors with literal expectations plus a
// queue-based reference model checked on every cycle by a monitor.

module tb_inst_encoder;

    typedef struct {
        logic [3:0]  f;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

`ifdef INST_ENCODER_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] imm;
    logic        addr_load;
    logic [31:0] addr_value;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_addr;
    logic        out_err;
    logic        err_sticky;
    logic [15:0] word_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [32:0] q[$];
    logic [31:0] log_inst[$];
    logic [31:0] log_addr[$];
    logic        log_err[$];
    logic [31:0] m_addr;
    logic [15:0] m_cnt;
    logic        m_sticky;
    logic        hold;
    logic [31:0] hold_inst;
    logic        hold_err;

    vec_t tbl[9];
    vec_t v_bad;
    vec_t v_ibig;
    vec_t v_bodd;

    inst_encoder dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .func3(func3), .func7(func7), .imm(imm),
        .addr_load(addr_load), .addr_value(addr_value),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err),
        .err_sticky(err_sticky), .word_cnt(word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_inst(input logic [3:0] f, input logic [6:0] op,
                                               input logic [4:0] d, input logic [4:0] s1,
                                               input logic [4:0] s2, input logic [2:0] f3,
                                               input logic [6:0] f7, input logic [31:0] im);
        logic [31:0] base;
        logic        sh;
        base = (32'(s1) << 15) | (32'(f3) << 12) | 32'(op);
        sh   = (op == 7'h13) && (f3 == 3'd1 || f3 == 3'd5);
        case (f)
            4'd1: return (32'(f7) << 25) | (32'(s2) << 20) | base | (32'(d) << 7);
            4'd2: if (sh) return (32'(f7) << 25) | ((im & 32'h1f) << 20) | base | (32'(d) << 7);
                  else    return ((im & 32'hfff) << 20) | base | (32'(d) << 7);
            4'd3: return (im & 32'hffff_f000) | (32'(d) << 7) | 32'(op);
            4'd4: return (((im >> 5) & 32'h7f) << 25) | (32'(s2) << 20) | base | ((im & 32'h1f) << 7);
            4'd5: return (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3f) << 25) |
                         (32'(s2) << 20) | base | (((im >> 1) & 32'hf) << 8) |
                         (((im >> 11) & 32'h1) << 7);
            4'd6: return (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3ff) << 21) |
                         (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hff) << 12) |
                         (32'(d) << 7) | 32'(op);
            4'd7: return ((im & 32'hfff) << 20) | base | (32'(d) << 7);
            default: return 32'h0000_0013;
        endcase
    endfunction

    function automatic logic model_err(input logic [3:0] f, input logic [6:0] op,
                                       input logic [2:0] f3, input logic [31:0] im);
        int  s;
        bit  sh;
        s  = $signed(im);
        sh = (op == 7'h13) && (f3 == 3'd1 || f3 == 3'd5);
        if (f == 4'd0 || f > 4'd7) return 1'b1;
        if (!RC) return 1'b0;
        case (f)
            4'd2: return sh ? (im > 32'd31) : (s < -2048 || s > 2047);
            4'd4: return (s < -2048 || s > 2047);
            4'd7: return (im > 32'd4095);
            4'd5: return (s < -4096 || s > 4095 || im[0]);
            4'd6: return (s < -(1 << 20) || s >= (1 << 20) || im[0]);
            4'd3: return ((im & 32'hfff) != 0);
            default: return 1'b0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_addr   = 32'h0;
            m_cnt    = 16'h0;
            m_sticky = 1'b0;
            hold     = 1'b0;
        end else begin
            chk("in_ready", {31'b0, in_ready}, {31'b0, (!flush && (q.size() < 2 || out_ready))});
            if (q.size() == 0) chk("idle_out_valid", {31'b0, out_valid}, 32'd0);
            if (q.size() == 2) chk("full_out_valid", {31'b0, out_valid}, 32'd1);
            chk("out_addr", out_addr, m_addr);
            chk("word_cnt", {16'b0, word_cnt}, {16'b0, m_cnt});
            chk("err_sticky", {31'b0, err_sticky}, {31'b0, m_sticky});
            if (out_valid && q.size() > 0) begin
                chk("out_inst", out_inst, q[0][31:0]);
                chk("out_err", {31'b0, out_err}, {31'b0, q[0][32]});
            end
            if (hold && out_valid) begin
                chk("stall_inst", out_inst, hold_inst);
                chk("stall_err", {31'b0, out_err}, {31'b0, hold_err});
            end
            hold      = out_valid && !out_ready && !flush;
            hold_inst = out_inst;
            hold_err  = out_err;
            if (flush) begin
                q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    log_inst.push_back(out_inst);
                    log_addr.push_back(out_addr);
                    log_err.push_back(out_err);
                    if (q.size() > 0) begin
                        m_sticky = m_sticky | q[0][32];
                        void'(q.pop_front());
                    end
                    m_cnt = m_cnt + 16'd1;
                    if (!addr_load) m_addr = m_addr + 32'd4;
                end
                if (in_valid && in_ready)
                    q.push_back({model_err(fmt, opcode, func3, imm),
                                 model_inst(fmt, opcode, rd, rs1, rs2, func3, func7, imm)});
            end
            if (addr_load) m_addr = {addr_value[31:2], 2'b00};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input vec_t v);
        fmt = v.f; opcode = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
        func3 = v.f3; func7 = v.f7; imm = v.imm;
        in_valid = 1'b1;
    endtask

    task automatic send(input vec_t v);
        int n;
        bit ok;
        set_in(v);
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 40) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0, required 1");
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        log_inst.delete();
        log_addr.delete();
        log_err.delete();
    endtask

    task automatic chk_log(input string name, input int idx, input logic [31:0] inst,
                           input logic [31:0] addr, input logic err);
        if (log_inst.size() <= idx) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: only %0d words emitted, required more than %0d", name, log_inst.size(), idx);
        end else begin
            chk({name, "_inst"}, log_inst[idx], inst);
            chk({name, "_addr"}, log_addr[idx], addr);
            chk({name, "_err"}, {31'b0, log_err[idx]}, {31'b0, err});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'd2, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,          32'h0050_0093};
        tbl[1] = '{4'd4, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,          32'h0020_A423};
        tbl[2] = '{4'd5, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFF_FFFC,  32'hFE20_8EE3};
        tbl[3] = '{4'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000,  32'h1234_52B7};
        tbl[4] = '{4'd6, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd8,          32'h0080_00EF};
        tbl[5] = '{4'd2, 7'h13, 5'd3, 5'd1, 5'd0, 3'd1, 7'h00, 32'd5,          32'h0050_9193};
        tbl[6] = '{4'd2, 7'h13, 5'd3, 5'd1, 5'd0, 3'd5, 7'h20, 32'd5,          32'h4050_D193};
        tbl[7] = '{4'd1, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0,          32'h0020_81B3};
        tbl[8] = '{4'd7, 7'h73, 5'd1, 5'd2, 5'd0, 3'd1, 7'h00, 32'h300,        32'h3001_10F3};
        v_bad  = '{4'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 32'd0,          32'h0000_0013};
        v_ibig = '{4'd2, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,       32'h8000_0093};
        v_bodd = '{4'd5, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd3,          32'h0020_8163};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; addr_load = 1'b0; addr_value = '0;
        out_ready = 1'b1;
        fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; func3 = '0; func7 = '0; imm = '0;
        tick();
        tick();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_err", {31'b0, out_err}, 32'd0);
        chk("rst_err_sticky", {31'b0, err_sticky}, 32'd0);
        chk("rst_word_cnt", {16'b0, word_cnt}, 32'd0);
        chk("rst_out_addr", out_addr, 32'd0);
        rst_n = 1'b1;
        tick();

        // Latency: addi lands two cycles after its handshake.
        send(tbl[0]);
        @(negedge clk);
        chk("lat1_out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat2_out_valid", {31'b0, out_valid}, 32'd1);
        chk("addi_inst", out_inst, 32'h0050_0093);
        chk("addi_addr", out_addr, 32'd0);
        @(posedge clk); #1;

        // Back-to-back stream with incrementing addresses.
        do_reset();
        for (int i = 1; i <= 8; i++) send(tbl[i]);
        repeat (4) tick();
        for (int i = 0; i < 8; i++) chk_log("stream", i, tbl[i+1].exp, 32'(i * 4), 1'b0);
        @(negedge clk);
        chk("stream_word_cnt", {16'b0, word_cnt}, 32'd8);
        @(posedge clk); #1;

        // Backpressure: two words buffered, third waits, order preserved.
        do_reset();
        out_ready = 1'b0;
        send(tbl[0]);
        send(tbl[1]);
        set_in(tbl[3]);
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_out_inst", out_inst, 32'h0050_0093);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(tbl[3]);
        repeat (4) tick();
        chk_log("bp0", 0, 32'h0050_0093, 32'd0, 1'b0);
        chk_log("bp1", 1, 32'h0020_A423, 32'd4, 1'b0);
        chk_log("bp2", 2, 32'h1234_52B7, 32'd8, 1'b0);

        // Address load during a handshake.
        do_reset();
        send(tbl[0]);
        tick();
        addr_load = 1'b1;
        addr_value = 32'h0000_1003;
        @(negedge clk);
        chk("aload_valid", {31'b0, out_valid}, 32'd1);
        @(posedge clk); #1;
        addr_load = 1'b0;
        send(tbl[1]);
        repeat (3) tick();
        chk_log("aload_old", 0, 32'h0050_0093, 32'd0, 1'b0);
        chk_log("aload_new", 1, 32'h0020_A423, 32'h0000_1000, 1'b0);

        // Illegal format, then flush with two words in flight.
        do_reset();
        send(v_bad);
        repeat (3) tick();
        chk_log("illegal", 0, 32'h0000_0013, 32'd0, 1'b1);
        @(negedge clk);
        chk("illegal_sticky", {31'b0, err_sticky}, 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(tbl[0]);
        send(tbl[1]);
        flush = 1'b1;
        out_ready = 1'b1;
        set_in(tbl[3]);
        @(negedge clk);
        chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_word_cnt", {16'b0, word_cnt}, 32'd1);
        chk("flush_sticky", {31'b0, err_sticky}, 32'd1);
        chk("flush_addr", out_addr, 32'd4);
        @(posedge clk); #1;
        repeat (2) tick();
        @(negedge clk);
        chk("flush_drop", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;

        // Immediate range boundaries.
        do_reset();
        send(v_ibig);
        send(v_bodd);
        repeat (4) tick();
        chk_log("imm2048", 0, 32'h8000_0093, 32'd0, RC);
        chk_log("bimm3", 1, 32'h0020_8163, 32'd4, RC);

        // Reset mid-operation drops in-flight words.
        out_ready = 1'b0;
        send(tbl[0]);
        send(tbl[1]);
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mrst_out_inst", out_inst, 32'd0);
        chk("mrst_word_cnt", {16'b0, word_cnt}, 32'd0);
        chk("mrst_sticky", {31'b0, err_sticky}, 32'd0);
        chk("mrst_addr", out_addr, 32'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        chk("mrst_idle", {31'b0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
